// File: rtl/blink_seq_ctrl.sv
// blink_seq_ctrl: plays a table of {period, high, rep} blink steps on o.
// Define BLINK_SEQ_READBACK_EN to add the combinational cfg_rdata port.
module blink_seq_ctrl #(
  parameter  int CNT_W = 24,
  parameter  int STEPS = 4,
  parameter  int REP_W = 8,
  localparam int AW    = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
`ifdef BLINK_SEQ_READBACK_EN
  output logic [2*CNT_W+REP_W-1:0] cfg_rdata,
`endif
  output logic             o,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             step_done,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);
  localparam logic [AW-1:0]    IDX_ONE = AW'(1);

  logic [CNT_W-1:0] tbl_per [STEPS];
  logic [CNT_W-1:0] tbl_hi  [STEPS];
  logic [REP_W-1:0] tbl_rep [STEPS];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rcnt_q, rcnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [REP_W-1:0] rep_q, rep_d;

  logic             ld;
  logic [AW-1:0]    ld_idx;
  logic [AW-1:0]    nidx;
  logic             win_end;
  logic             sd_d, dn_d;
  logic             o_d, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_per[i] <= '0;
        tbl_hi[i]  <= '0;
        tbl_rep[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_per[cfg_addr] <= cfg_period;
      tbl_hi[cfg_addr]  <= cfg_high;
      tbl_rep[cfg_addr] <= cfg_rep;
    end
  end

`ifdef BLINK_SEQ_READBACK_EN
  assign cfg_rdata = {tbl_per[cfg_addr],
                      tbl_hi[cfg_addr],
                      tbl_rep[cfg_addr]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      idx_q     <= '0;
      per_q     <= '0;
      hi_q      <= '0;
      rep_q     <= '0;
      o         <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      idx_q     <= idx_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      rep_q     <= rep_d;
      o         <= o_d;
      busy      <= busy_d;
      step_done <= sd_d;
      done      <= dn_d;
    end
  end

  assign step_idx = idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    idx_d   = idx_q;
    per_d   = per_q;
    hi_d    = hi_q;
    rep_d   = rep_q;
    sd_d    = 1'b0;
    dn_d    = 1'b0;
    ld      = 1'b0;
    ld_idx  = '0;
    nidx    = idx_q + IDX_ONE;
    win_end = (cnt_q == per_q - CNT_ONE);
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start && !stop) begin
          if (tbl_per[0] != '0) begin
            state_d = RUN;
            ld      = 1'b1;
          end else begin
            dn_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (!win_end) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (rcnt_q != rep_q) begin
          cnt_d  = '0;
          rcnt_d = rcnt_q + REP_ONE;
        end else begin
          sd_d = 1'b1;
          // a wrap without loop_en ends just like a terminator
          if ((nidx != '0 || loop_en) &&
              tbl_per[nidx] != '0) begin
            ld     = 1'b1;
            ld_idx = nidx;
          end else if (loop_en && tbl_per[0] != '0) begin
            ld = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            dn_d    = 1'b1;
          end
        end
      end
    endcase
    if (ld) begin
      idx_d  = ld_idx;
      cnt_d  = '0;
      rcnt_d = '0;
      per_d  = tbl_per[ld_idx];
      hi_d   = tbl_hi[ld_idx];
      rep_d  = tbl_rep[ld_idx];
    end
  end

  always_comb begin
    busy_d = (state_d == RUN);
    o_d    = busy_d && (cnt_d < hi_d);
  end

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// tb_blink_seq_ctrl: vector table, directed sequences and
// randomized traffic against a window-position reference model.
module tb_blink_seq_ctrl;

  localparam int STEPS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_period;
  logic [23:0] cfg_high;
  logic [7:0]  cfg_rep;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic        o;
  logic        busy;
  logic [1:0]  step_idx;
  logic        step_done;
  logic        done;
`ifdef BLINK_SEQ_READBACK_EN
  logic [55:0] cfg_rdata;
`endif

  blink_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_rep    (cfg_rep),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
`ifdef BLINK_SEQ_READBACK_EN
    .cfg_rdata  (cfg_rdata),
`endif
    .o          (o),
    .busy       (busy),
    .step_idx   (step_idx),
    .step_done  (step_done),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference model: position inside the current step's
  // period*(rep+1) span, output from pos % period
  typedef struct packed {
    logic [23:0] per;
    logic [23:0] hi;
    logic [7:0]  rep;
  } ent_t;

  ent_t   mt [STEPS];
  ent_t   mcur;
  bit     m_busy, m_o, m_sd, m_dn;
  int     m_idx;
  longint m_pos;

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) mt[i] = '0;
    mcur = '0;
    m_busy = 0; m_o = 0; m_sd = 0; m_dn = 0;
    m_idx = 0; m_pos = 0;
  endtask

  task automatic model_edge();
    int nx;
    bit ld;
    int li;
    if (rst) begin
      model_reset();
      return;
    end
    m_sd = 0; m_dn = 0; ld = 0; li = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        if (mt[0].per != 0) ld = 1;
        else m_dn = 1;
      end
    end else if (stop) begin
      m_busy = 0;
    end else begin
      m_pos++;
      if (m_pos == longint'(mcur.per) * (longint'(mcur.rep) + 1)) begin
        m_sd = 1;
        nx = (m_idx + 1) % STEPS;
        if ((nx != 0 || loop_en) && mt[nx].per != 0) begin
          ld = 1; li = nx;
        end else if (loop_en && mt[0].per != 0) begin
          ld = 1; li = 0;
        end else begin
          m_busy = 0; m_dn = 1;
        end
      end
    end
    if (ld) begin
      m_busy = 1; m_idx = li; mcur = mt[li]; m_pos = 0;
    end
    if (!m_busy) m_idx = 0;
    if (cfg_we) mt[cfg_addr] = {cfg_period, cfg_high, cfg_rep};
    if (m_busy) m_o = (m_pos % longint'(mcur.per)) < longint'(mcur.hi);
    else m_o = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, int p, int h, int r);
    cfg_we = 1;
    cfg_addr = 2'(a);
    cfg_period = 24'(p);
    cfg_high = 24'(h);
    cfg_rep = 8'(r);
    tick();
    cfg_we = 0;
  endtask

  task automatic halt();
    stop = 1;
    tick();
    stop = 0;
    tick();
  endtask

  typedef struct {
    logic [3:0][7:0] per;
    logic [3:0][7:0] hi;
    logic [3:0][7:0] rep;
    bit              loop_en;
    int              ncyc;
    logic [31:0]     eo;
    logic [31:0]     eb;
    logic [31:0]     es;
    logic [31:0]     ed;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{32'h0, 32'h0, 32'h0, 1'b0, 3,
              32'h0, 32'h0, 32'h0, 32'h1};
    vt[1] = '{32'h0F, 32'h05, 32'h0, 1'b0, 17,
              32'h1F, 32'h7FFF, 32'h8000, 32'h8000};
    vt[2] = '{32'h0604, 32'h0301, 32'h0002, 1'b0, 20,
              32'h7111, 32'h3FFFF, 32'h41000, 32'h40000};
    vt[3] = '{32'h0F, 32'h00, 32'h0, 1'b0, 17,
              32'h0, 32'h7FFF, 32'h8000, 32'h8000};
    vt[4] = '{32'h0F, 32'h14, 32'h0, 1'b0, 17,
              32'h7FFF, 32'h7FFF, 32'h8000, 32'h8000};
    vt[5] = '{32'h02020202, 32'h01010101, 32'h0, 1'b0, 10,
              32'h55, 32'hFF, 32'h154, 32'h100};
    vt[6] = '{32'h03, 32'h01, 32'h0, 1'b1, 10,
              32'h249, 32'h3FF, 32'h248, 32'h0};

    rst = 1; cfg_we = 0; cfg_addr = 0;
    cfg_period = 0; cfg_high = 0; cfg_rep = 0;
    start = 0; stop = 0; loop_en = 0;
    model_reset();
    #1;
    chk("reset_outs", 64'({o, busy, step_done, done, step_idx}), 64'(0));
    tick();
    tick();
    rst = 0;
    tick();

    for (int v = 0; v < 7; v++) begin
      for (int e = 0; e < STEPS; e++)
        wr(e, vt[v].per[e], vt[v].hi[e], vt[v].rep[e]);
      loop_en = vt[v].loop_en;
      start = 1;
      tick();
      start = 0;
      for (int c = 0; c < vt[v].ncyc; c++) begin
        chk($sformatf("vec%0d_c%0d", v, c),
            64'({o, busy, step_done, done}),
            64'({vt[v].eo[c], vt[v].eb[c], vt[v].es[c], vt[v].ed[c]}));
        tick();
      end
      halt();
    end

    // loop over all four steps, stop on a step boundary
    for (int e = 0; e < STEPS; e++) wr(e, 2, 1, 0);
    loop_en = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("loop_idx_c%0d", c), 64'(step_idx), 64'((c / 2) % 4));
      chk($sformatf("loop_done_c%0d", c), 64'(done), 64'(0));
      if (c == 11) stop = 1;
      tick();
    end
    stop = 0;
    chk("stop_outs", 64'({o, busy, step_done, done, step_idx}), 64'(0));
    tick();
    chk("stop_after", 64'({busy, done}), 64'(0));
    tick();

    // live rewrite of the running entry
    wr(0, 10, 5, 1);
    wr(1, 0, 0, 0);
    loop_en = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 26; c++) begin
      chk($sformatf("live_c%0d", c),
          64'({o, busy, step_done, step_idx}),
          64'({(c < 20) ? ((c % 10) < 5) : 1'b1, 1'b1,
               (c == 20 || c == 24), 2'b00}));
      if (c == 3) begin
        cfg_we = 1; cfg_addr = 0;
        cfg_period = 4; cfg_high = 4; cfg_rep = 0;
`ifdef BLINK_SEQ_READBACK_EN
        #1;
        chk("rdata_old", 64'(cfg_rdata), 64'({24'd10, 24'd5, 8'd1}));
`endif
      end
      tick();
      if (c == 3) begin
        cfg_we = 0;
`ifdef BLINK_SEQ_READBACK_EN
        chk("rdata_new", 64'(cfg_rdata), 64'({24'd4, 24'd4, 8'd0}));
`endif
      end
    end
    halt();

    // asynchronous reset mid-run, then start on an empty table
    loop_en = 0;
    wr(0, 15, 5, 0);
    wr(1, 0, 0, 0);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("pre_rst", 64'({o, busy}), 64'(2'b11));
    #2;
    rst = 1;
    #1;
    chk("async_rst", 64'({o, busy, step_idx}), 64'(0));
    tick();
    rst = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    chk("empty_c0", 64'({busy, done}), 64'(2'b01));
    tick();
    chk("empty_c1", 64'({busy, done}), 64'(2'b00));
    tick();
    chk("empty_c2", 64'({busy, done}), 64'(2'b00));

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 5) == 0) ?
                   24'd0 : 24'($urandom_range(1, 5));
      cfg_high = 24'($urandom_range(0, 6));
      cfg_rep = 8'($urandom_range(0, 2));
      tick();
      chk($sformatf("rand%0d", n),
          64'({o, busy, step_done, done}),
          64'({m_o, m_busy, m_sd, m_dn}));
      if (m_busy)
        chk($sformatf("rand_idx%0d", n), 64'(step_idx), 64'(m_idx));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
